// File: rtl/wb_stage_pkg.sv
// Shared constants for the write-back stage: load op encodings and reset word.
package wb_stage_pkg;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [2:0] LB_OP  = 3'b000;
    localparam logic [2:0] LBU_OP = 3'b001;
    localparam logic [2:0] LH_OP  = 3'b010;
    localparam logic [2:0] LHU_OP = 3'b011;
    localparam logic [2:0] LW_OP  = 3'b100;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load alignment: selects the byte or halfword at the load
// address and sign- or zero-extends it. Unknown ops behave as LW.
module load_align
    import wb_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]    op_i,
    input  logic [1:0]    addr_lo_i,
    input  logic [DW-1:0] rd_i,
    output logic [DW-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd_i[{addr_lo_i, 3'b000} +: 8];
        // Halfword misalignment is trapped upstream, so addr_lo[0] is ignored.
        half_sel = addr_lo_i[1] ? rd_i[31:16] : rd_i[15:0];
        case (op_i)
            LB_OP:   data_o = {{(DW-8){byte_sel[7]}}, byte_sel};
            LBU_OP:  data_o = {{(DW-8){1'b0}}, byte_sel};
            LH_OP:   data_o = {{(DW-16){half_sel[15]}}, half_sel};
            LHU_OP:  data_o = {{(DW-16){1'b0}}, half_sel};
            default: data_o = rd_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: registers the MEM result, merges SRAM load data (buffered
// across stalls), and drives the regfile write port plus the debug trace.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          mem_valid,
    input  logic [31:0]   mem_pc,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_waddr,
    input  logic [DW-1:0] mem_wdata,
    input  logic          mem_load,
    input  logic [2:0]    mem_load_op,
    input  logic [1:0]    mem_addr_lo,
    input  logic [DW-1:0] data_sram_rdata,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [31:0]   debug_wb_pc,
    output logic [3:0]    debug_wb_rf_wen,
    output logic [AW-1:0] debug_wb_rf_wnum,
    output logic [DW-1:0] debug_wb_rf_wdata
);

    logic          valid_q, valid_d;
    logic [31:0]   pc_q, pc_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          load_q, load_d;
    logic [2:0]    op_q, op_d;
    logic [1:0]    addr_lo_q, addr_lo_d;
    logic          buf_valid_q, buf_valid_d;
    logic [DW-1:0] rbuf_q, rbuf_d;

    logic [DW-1:0] rd;
    logic [DW-1:0] aligned;

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        we_d        = we_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        load_d      = load_q;
        op_d        = op_q;
        addr_lo_d   = addr_lo_q;
        buf_valid_d = buf_valid_q;
        rbuf_d      = rbuf_q;
        if (flush) begin
            valid_d     = 1'b0;
            buf_valid_d = 1'b0;
        end else if (stall) begin
            // SRAM output is only guaranteed in the first WB cycle; keep a copy.
            if (valid_q && load_q && !buf_valid_q) begin
                rbuf_d      = data_sram_rdata;
                buf_valid_d = 1'b1;
            end
        end else begin
            valid_d     = mem_valid;
            pc_d        = mem_pc;
            we_d        = mem_we;
            waddr_d     = mem_waddr;
            wdata_d     = mem_wdata;
            load_d      = mem_load;
            op_d        = mem_load_op;
            addr_lo_d   = mem_addr_lo;
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            load_q      <= 1'b0;
            op_q        <= '0;
            addr_lo_q   <= '0;
            buf_valid_q <= 1'b0;
            rbuf_q      <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            load_q      <= load_d;
            op_q        <= op_d;
            addr_lo_q   <= addr_lo_d;
            buf_valid_q <= buf_valid_d;
            rbuf_q      <= rbuf_d;
        end
    end

    assign rd = buf_valid_q ? rbuf_q : data_sram_rdata;

    load_align #(.DW(DW)) u_load_align (
        .op_i      (op_q),
        .addr_lo_i (addr_lo_q),
        .rd_i      (rd),
        .data_o    (aligned)
    );

    assign rf_we    = valid_q && we_q && (waddr_q != '0);
    assign rf_waddr = waddr_q;
    assign rf_wdata = load_q ? aligned : wdata_q;

    assign debug_wb_pc       = valid_q ? pc_q : ZERO_WORD;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule
